sprite_eval: RTL and testbench



---
 rtl/sprite_eval.sv | 166 ++++++++++++++++
 tb/tb_sprite_eval.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_eval.sv
// sprite_eval: per-scanline sprite evaluation, primary OAM scan into secondary OAM.
// Define SPRITE_OVF_BUG_EN to reproduce the hardware's diagonal OAM walk during overflow search.
module sprite_eval #(
    parameter int         NUM_SPRITES = 8,
    parameter logic [7:0] CLEAR_VAL   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] cycle,
    input  logic [8:0] scanline,
    input  logic       render_en,
    input  logic       sp_size16,
    output logic [7:0] oam_addr,
    input  logic [7:0] oam_data,
    output logic [4:0] oam2_addr,
    output logic [7:0] oam2_wdata,
    output logic       oam2_we,
    output logic [3:0] sp_count,
    output logic       sp0_next,
    output logic       sp_overflow
);
    localparam logic [3:0] NS = 4'(NUM_SPRITES);

    typedef enum logic [2:0] {IDLE, CLEAR, SCAN_Y, COPY, OVF, DONE} state_t;

    state_t     state_q, state_d;
    logic [5:0] n_q, n_d;
    logic [1:0] m_q, m_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sp0_q, sp0_d;
    logic [7:0] lat_q;
    logic [3:0] sp_count_q;
    logic       sp0_next_q, sp_ovf_q;
    logic       active, even, last, in_range, ovf_hit, eol;
    logic [8:0] diff;

    assign active   = render_en && scanline < 9'd240;
    assign even     = !cycle[0];
    assign last     = n_q == 6'd63;
    // Y values >= 240 wrap the subtraction to a large value and so never match
    assign diff     = scanline - {1'b0, lat_q};
    assign in_range = sp_size16 ? diff < 9'd16 : diff < 9'd8;
    assign ovf_hit  = active && state_q == OVF && even && in_range;
    assign eol      = active && cycle == 9'd256 && state_q inside {SCAN_Y, COPY, OVF, DONE};

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        sp0_d      = sp0_q;
        oam_addr   = 8'd0;
        oam2_addr  = 5'd0;
        oam2_wdata = 8'd0;
        oam2_we    = 1'b0;
        if (!active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cycle == 9'd0) state_d = CLEAR;
                CLEAR: begin
                    if (even) begin
                        oam2_we    = 1'b1;
                        oam2_addr  = 5'((cycle >> 1) - 9'd1);
                        oam2_wdata = CLEAR_VAL;
                    end
                    if (cycle == 9'd64) begin
                        state_d = SCAN_Y;
                        n_d     = 6'd0;
                        m_d     = 2'd0;
                        cnt_d   = 4'd0;
                        sp0_d   = 1'b0;
                    end
                end
                SCAN_Y: begin
                    oam_addr = {n_q, 2'b00};
                    if (even) begin
                        oam2_we    = cnt_q < NS;
                        oam2_addr  = 5'({cnt_q, 2'b00});
                        oam2_wdata = lat_q;
                        if (in_range) begin
                            state_d = COPY;
                            m_d     = 2'd1;
                        end else begin
                            n_d     = n_q + 6'd1;
                            state_d = last ? DONE : SCAN_Y;
                        end
                    end
                end
                COPY: begin
                    oam_addr = {n_q, m_q};
                    if (even) begin
                        oam2_we    = 1'b1;
                        oam2_addr  = 5'({cnt_q, m_q});
                        oam2_wdata = m_q == 2'd2 ? lat_q & 8'hE3 : lat_q;
                        if (m_q == 2'd3) begin
                            m_d     = 2'd0;
                            cnt_d   = cnt_q + 4'd1;
                            n_d     = n_q + 6'd1;
                            sp0_d   = sp0_q | (n_q == 6'd0);
                            state_d = last ? DONE : (cnt_q + 4'd1 == NS) ? OVF : SCAN_Y;
                        end else begin
                            m_d = m_q + 2'd1;
                        end
                    end
                end
                OVF: begin
                    oam_addr = {n_q, m_q};
                    if (even) begin
`ifdef SPRITE_OVF_BUG_EN
                        if (in_range) begin
                            {n_d, m_d} = {n_q, m_q} + 8'd3;
                            state_d    = DONE;
                        end else begin
                            n_d     = n_q + 6'd1;
                            m_d     = m_q + 2'd1;
                            state_d = last ? DONE : OVF;
                        end
`else
                        if (in_range) begin
                            state_d = DONE;
                        end else begin
                            n_d     = n_q + 6'd1;
                            state_d = last ? DONE : OVF;
                        end
`endif
                    end
                end
                DONE: oam_addr = {n_q, 2'b00};
                default: state_d = IDLE;
            endcase
            if (cycle == 9'd256) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_q        <= 6'd0;
            m_q        <= 2'd0;
            cnt_q      <= 4'd0;
            sp0_q      <= 1'b0;
            lat_q      <= 8'd0;
            sp_count_q <= 4'd0;
            sp0_next_q <= 1'b0;
            sp_ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            sp0_q   <= sp0_d;
            if (active && cycle[0]) lat_q <= oam_data;
            if (eol) begin
                sp_count_q <= cnt_d;
                sp0_next_q <= sp0_d;
            end
            if (scanline == 9'd261 && cycle == 9'd1) sp_ovf_q <= 1'b0;
            else if (ovf_hit) sp_ovf_q <= 1'b1;
        end
    end

    assign sp_count    = sp_count_q;
    assign sp0_next    = sp0_next_q;
    assign sp_overflow = sp_ovf_q;
endmodule

// File: tb/tb_sprite_eval.sv
// tb_sprite_eval: directed bench for sprite_eval with behavioural primary and secondary OAM.
module tb_sprite_eval;
    logic       clk = 1'b0;
    logic       rst_n, render_en, sp_size16, oam2_we, sp0_next, sp_overflow;
    logic [8:0] cycle, scanline;
    logic [7:0] oam_addr, oam_data, oam2_wdata;
    logic [4:0] oam2_addr;
    logic [3:0] sp_count;
    logic [7:0] oam [256];
    logic [7:0] oam2 [32];
    int         n_cmp = 0, n_bad = 0, clr_wr = 0, odd_wr = 0, base;
    logic [31:0] exp_ovf;

    sprite_eval dut (
        .clk(clk), .rst_n(rst_n), .cycle(cycle), .scanline(scanline),
        .render_en(render_en), .sp_size16(sp_size16), .oam_addr(oam_addr),
        .oam_data(oam_data), .oam2_addr(oam2_addr), .oam2_wdata(oam2_wdata),
        .oam2_we(oam2_we), .sp_count(sp_count), .sp0_next(sp0_next),
        .sp_overflow(sp_overflow)
    );

    always #5 clk = ~clk;
    assign oam_data = oam[oam_addr];

    always @(posedge clk) begin
        if (oam2_we) begin
            oam2[oam2_addr] <= oam2_wdata;
            if (cycle[0]) odd_wr <= odd_wr + 1;
            if (cycle >= 9'd1 && cycle <= 9'd64) clr_wr <= clr_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int sl, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            @(negedge clk);
            scanline = 9'(sl);
            cycle    = 9'(c);
        end
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
    endtask

    task automatic set_spr(input int i, input logic [7:0] y, input logic [7:0] t,
                           input logic [7:0] a, input logic [7:0] x);
        oam[4*i] = y; oam[4*i+1] = t; oam[4*i+2] = a; oam[4*i+3] = x;
    endtask

    task automatic chk_slot(input string tag, input int s, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        chk({tag, ".y"}, 32'(oam2[4*s]),   32'(b0));
        chk({tag, ".t"}, 32'(oam2[4*s+1]), 32'(b1));
        chk({tag, ".a"}, 32'(oam2[4*s+2]), 32'(b2));
        chk({tag, ".x"}, 32'(oam2[4*s+3]), 32'(b3));
    endtask

    initial begin
        rst_n = 1'b0; render_en = 1'b0; sp_size16 = 1'b0; cycle = 9'd0; scanline = 9'd0;
        clear_oam();
        repeat (3) @(negedge clk);
        #1;
        chk("rst.oam_addr", 32'(oam_addr), 0);
        chk("rst.we", 32'(oam2_we), 0);
        chk("rst.oam2_addr", 32'(oam2_addr), 0);
        chk("rst.wdata", 32'(oam2_wdata), 0);
        chk("rst.count", 32'(sp_count), 0);
        chk("rst.sp0", 32'(sp0_next), 0);
        chk("rst.ovf", 32'(sp_overflow), 0);
        rst_n = 1'b1;
        render_en = 1'b1;

        // empty line: clear phase plus Y-byte copies, nothing selected
        base = clr_wr;
        run(10, 0, 257);
        chk("clr.writes", 32'(clr_wr - base), 32);
        for (int i = 0; i < 32; i++) chk($sformatf("clr.oam2[%0d]", i), 32'(oam2[i]), 32'hFF);
        chk("clr.count", 32'(sp_count), 0);
        chk("clr.sp0", 32'(sp0_next), 0);
        chk("clr.ovf", 32'(sp_overflow), 0);
        run(10, 258, 340);

        // sprites 0, 5, 63 in range at line 10
        set_spr(0, 8'd8, 8'h11, 8'hFF, 8'h20);
        set_spr(5, 8'd8, 8'h55, 8'h01, 8'h50);
        set_spr(63, 8'd8, 8'h3F, 8'h1C, 8'h70);
        run(10, 0, 257);
        chk_slot("sel.s0", 0, 8'h08, 8'h11, 8'hE3, 8'h20);
        chk_slot("sel.s1", 1, 8'h08, 8'h55, 8'h01, 8'h50);
        chk_slot("sel.s2", 2, 8'h08, 8'h3F, 8'h00, 8'h70);
        chk("sel.s3y", 32'(oam2[12]), 32'hFF);
        chk("sel.count", 32'(sp_count), 3);
        chk("sel.sp0", 32'(sp0_next), 1);
        run(10, 258, 340);

        // 8x16 range: diff 12 misses in 8x8, hits in 8x16
        clear_oam();
        set_spr(3, 8'd0, 8'h33, 8'hFF, 8'h44);
        run(12, 0, 257);
        chk("h8.count", 32'(sp_count), 0);
        chk("h8.s0y", 32'(oam2[0]), 32'hFF);
        run(12, 258, 340);
        sp_size16 = 1'b1;
        run(12, 0, 257);
        chk_slot("h16.s0", 0, 8'h00, 8'h33, 8'hE3, 8'h44);
        chk("h16.count", 32'(sp_count), 1);
        chk("h16.sp0", 32'(sp0_next), 0);
        run(12, 258, 340);
        sp_size16 = 1'b0;

        // nine sprites in range: overflow, held until line 261 dot 1
        clear_oam();
        for (int i = 0; i < 9; i++) set_spr(i, 8'd20, 8'(i), 8'h00, 8'(8'h80 + i));
        run(22, 0, 257);
        chk("ovf.flag", 32'(sp_overflow), 1);
        chk("ovf.count", 32'(sp_count), 8);
        chk("ovf.sp0", 32'(sp0_next), 1);
        chk_slot("ovf.s7", 7, 8'd20, 8'h07, 8'h00, 8'h87);
        run(22, 258, 340);
        run(239, 0, 340);
        chk("ovf.hold239", 32'(sp_overflow), 1);
        run(261, 0, 1);
        chk("ovf.hold261c1", 32'(sp_overflow), 1);
        run(261, 2, 2);
        chk("ovf.clear261", 32'(sp_overflow), 0);
        run(261, 3, 340);

        // render_en dropped mid-line: no writes, count holds
        clear_oam();
        set_spr(0, 8'd45, 8'h01, 8'h00, 8'h10);
        set_spr(1, 8'd45, 8'h02, 8'h00, 8'h20);
        run(49, 0, 340);
        chk("dis.count_pre", 32'(sp_count), 2);
        run(50, 0, 100);
        render_en = 1'b0;
        for (int c = 101; c <= 104; c++) begin
            run(50, c, c);
            #1;
            chk($sformatf("dis.we%0d", c), 32'(oam2_we), 0);
            chk($sformatf("dis.addr%0d", c), 32'(oam_addr), 0);
        end
        run(50, 105, 340);
        chk("dis.count_hold", 32'(sp_count), 2);

        // asynchronous reset in the middle of the scan
        render_en = 1'b1;
        run(60, 0, 80);
        #1;
        chk("mid.we", 32'(oam2_we), 1);
        chk("mid.oam_addr", 32'(oam_addr), 28);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.we", 32'(oam2_we), 0);
        chk("arst.oam_addr", 32'(oam_addr), 0);
        chk("arst.oam2_addr", 32'(oam2_addr), 0);
        chk("arst.wdata", 32'(oam2_wdata), 0);
        chk("arst.count", 32'(sp_count), 0);
        chk("arst.sp0", 32'(sp0_next), 0);
        chk("arst.ovf", 32'(sp_overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 8 hits, sprite 8 Y miss, sprite 9 Y miss with tile byte in range
        clear_oam();
        for (int i = 0; i < 8; i++) set_spr(i, 8'd30, 8'h00, 8'h00, 8'h00);
        oam[37] = 8'd30;
`ifdef SPRITE_OVF_BUG_EN
        exp_ovf = 32'd1;
`else
        exp_ovf = 32'd0;
`endif
        run(32, 0, 257);
        chk("bug.count", 32'(sp_count), 8);
        chk("bug.ovf", 32'(sp_overflow), exp_ovf);
        run(32, 258, 340);
        chk("odd_writes", 32'(odd_wr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
